// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird game: phase codes, bus widths, tick rate
// and the countdown conversion used by the phase sequencer and the VGA overlay.
package game_pkg;

  localparam int unsigned SCORE_W       = 16;
  localparam int unsigned COORD_W       = 10;
  localparam int unsigned TICKS_PER_SEC = 10;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_READY = 3'd1,
    PH_PLAY  = 3'd2,
    PH_DYING = 3'd3,
    PH_OVER  = 3'd4,
    PH_PAUSE = 3'd5
  } phase_t;

  // Whole seconds left (rounded up) for a tick count, clamped to the 3..1 display range.
  function automatic logic [1:0] countdown_secs(input logic [7:0] ticks);
    logic [7:0] secs;
    secs = ticks / 8'(TICKS_PER_SEC);
    if (secs >= 8'd2) return 2'd3;
    return 2'(secs + 8'd1);
  endfunction

endpackage

// File: rtl/game_sequencer_tick_timer.sv
// tick_timer: 8-bit loadable down-counter that stops at zero instead of wrapping.
module tick_timer (
  input  logic       clk_100ms,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_dec,
  output logic [7:0] o_value,
  output logic       o_zero
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == 8'd0);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: phase controller IDLE->READY->PLAY->DYING->OVER->READY for the game.
// Optional GAME_PAUSE_EN adds pause_i and the PAUSE phase (code 5).
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned        READY_TICKS   = 30,
  parameter int unsigned        DEATH_TICKS   = 20,
  parameter int unsigned        HOLDOFF_TICKS = 10,
  parameter int unsigned        BLINK_HALF    = 5,
  parameter logic [COORD_W-1:0] GROUND_Y      = '0
) (
  input  logic               clk_100ms,
  input  logic               rst,
  input  logic               btn_i,
  input  logic               fail_i,
  input  logic [COORD_W-1:0] bird_y_i,
  input  logic [SCORE_W-1:0] score_i,
`ifdef GAME_PAUSE_EN
  input  logic               pause_i,
`endif
  output logic               phys_rst_n,
  output logic               phys_run,
  output logic               flap_o,
  output logic [2:0]         phase_o,
  output logic [1:0]         countdown_o,
  output logic [SCORE_W-1:0] final_score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record,
  output logic               blink_o
);

  localparam logic [2:0] S_IDLE  = PH_IDLE;
  localparam logic [2:0] S_READY = PH_READY;
  localparam logic [2:0] S_PLAY  = PH_PLAY;
  localparam logic [2:0] S_DYING = PH_DYING;
  localparam logic [2:0] S_OVER  = PH_OVER;
`ifdef GAME_PAUSE_EN
  localparam logic [2:0] S_PAUSE = PH_PAUSE;
`endif

  localparam logic [7:0] READY_LOAD   = 8'(READY_TICKS - 1);
  localparam logic [7:0] DEATH_LOAD   = 8'(DEATH_TICKS - 1);
  localparam logic [7:0] HOLDOFF_LOAD = 8'(HOLDOFF_TICKS);
  localparam logic [7:0] BLINK_LAST   = 8'(BLINK_HALF - 1);

  logic [2:0]         r_phase;
  logic               r_btn_q;
  logic               r_phys_rst_n;
  logic               r_phys_run;
  logic               r_flap;
  logic [1:0]         r_countdown;
  logic [SCORE_W-1:0] r_final_score;
  logic [SCORE_W-1:0] r_high_score;
  logic               r_new_record;
  logic               r_blink;
  logic [7:0]         r_blink_cnt;

  logic [2:0] w_phase_nxt;
  logic       w_rise;
  logic       w_tmr_load;
  logic [7:0] w_tmr_val;
  logic       w_tmr_dec;
  logic [7:0] w_tmr_value;
  logic       w_tmr_zero;
  logic [7:0] w_tmr_next;
  logic       w_restart;
  logic       w_flap;
  logic       w_latch_score;
  logic       w_enter_over;
  logic       w_blink_phase;

  assign w_rise = btn_i & ~r_btn_q;

`ifdef GAME_PAUSE_EN
  logic r_pause_q;
  logic w_pause_rise;
  assign w_pause_rise = pause_i & ~r_pause_q;

  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) r_pause_q <= 1'b0;
    else      r_pause_q <= pause_i;
  end
`endif

  tick_timer u_phase_timer (
    .clk_100ms  (clk_100ms),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_value    (w_tmr_value),
    .o_zero     (w_tmr_zero)
  );

  // Mirror of the timer's next value so the countdown output lines up with the phase.
  assign w_tmr_next = w_tmr_load ? w_tmr_val :
                      ((w_tmr_dec && !w_tmr_zero) ? (w_tmr_value - 8'd1) : w_tmr_value);

  always_comb begin
    w_phase_nxt   = r_phase;
    w_tmr_load    = 1'b0;
    w_tmr_val     = '0;
    w_tmr_dec     = 1'b0;
    w_restart     = 1'b0;
    w_flap        = 1'b0;
    w_latch_score = 1'b0;
    w_enter_over  = 1'b0;
    case (r_phase)
      S_IDLE: begin
        if (w_rise) begin
          w_phase_nxt = S_READY;
          w_tmr_load  = 1'b1;
          w_tmr_val   = READY_LOAD;
          w_restart   = 1'b1;
        end
      end
      S_READY: begin
        if (w_tmr_zero) w_phase_nxt = S_PLAY;
        else            w_tmr_dec   = 1'b1;
      end
      S_PLAY: begin
        // Collision outranks both pause and flap in the same tick.
        if (fail_i) begin
          w_phase_nxt   = S_DYING;
          w_tmr_load    = 1'b1;
          w_tmr_val     = DEATH_LOAD;
          w_latch_score = 1'b1;
        end
`ifdef GAME_PAUSE_EN
        else if (w_pause_rise) begin
          w_phase_nxt = S_PAUSE;
        end
`endif
        else if (w_rise) begin
          w_flap = 1'b1;
        end
      end
      S_DYING: begin
        if (w_tmr_zero || (bird_y_i <= GROUND_Y)) begin
          w_phase_nxt  = S_OVER;
          w_tmr_load   = 1'b1;
          w_tmr_val    = HOLDOFF_LOAD;
          w_enter_over = 1'b1;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_OVER: begin
        if (!w_tmr_zero) begin
          w_tmr_dec = 1'b1;
        end else if (w_rise) begin
          w_phase_nxt = S_READY;
          w_tmr_load  = 1'b1;
          w_tmr_val   = READY_LOAD;
          w_restart   = 1'b1;
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (w_pause_rise) w_phase_nxt = S_PLAY;
      end
`endif
      default: w_phase_nxt = S_IDLE;
    endcase
  end

  assign w_blink_phase = (w_phase_nxt == S_IDLE) || (w_phase_nxt == S_OVER);

  always_ff @(posedge clk_100ms or negedge rst) begin
    if (!rst) begin
      r_phase       <= S_IDLE;
      r_btn_q       <= 1'b0;
      r_phys_rst_n  <= 1'b1;
      r_phys_run    <= 1'b0;
      r_flap        <= 1'b0;
      r_countdown   <= '0;
      r_final_score <= '0;
      r_high_score  <= '0;
      r_new_record  <= 1'b0;
      r_blink       <= 1'b0;
      r_blink_cnt   <= '0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_btn_q      <= btn_i;
      r_phys_rst_n <= ~w_restart;
      r_phys_run   <= (w_phase_nxt == S_PLAY);
      r_flap       <= w_flap;
      r_countdown  <= (w_phase_nxt == S_READY) ? countdown_secs(w_tmr_next) : 2'd0;

      if (w_latch_score) r_final_score <= score_i;

      if (w_enter_over) begin
        if (r_final_score > r_high_score) begin
          r_high_score <= r_final_score;
          r_new_record <= 1'b1;
        end else begin
          r_new_record <= 1'b0;
        end
      end else if (w_restart) begin
        r_new_record <= 1'b0;
      end

      // Blink phase restarts from zero whenever IDLE/OVER is entered.
      if (!w_blink_phase || (w_phase_nxt != r_phase)) begin
        r_blink_cnt <= '0;
        r_blink     <= 1'b0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink     <= ~r_blink;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  assign phase_o     = r_phase;
  assign phys_rst_n  = r_phys_rst_n;
  assign phys_run    = r_phys_run;
  assign flap_o      = r_flap;
  assign countdown_o = r_countdown;
  assign final_score = r_final_score;
  assign high_score  = r_high_score;
  assign new_record  = r_new_record;
  assign blink_o     = r_blink;

endmodule
